// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - register file access bundle: read, write-back, issue and init status
//
// Purpose: carries every non-clock/reset signal of regfile_sb.
// Ports (signals):
//   init_busy            status, high while the post-reset clear sweep runs
//   rs1_addr / rs2_addr  read addresses
//   rs1_data / rs2_data  combinational read data
//   rs1_pend / rs2_pend  outstanding-write flags for the read addresses
//   we0/waddr0/wdata0    write-back port 0
//   we1/waddr1/wdata1    write-back port 1 (wins over port 0)
//   issue_valid/issue_rd destination register of the instruction issued this cycle
// Modports: master drives addresses/writes/issue, slave (the register file) drives data/pend/busy.

interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            init_busy;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_pend;
    logic            rs2_pend;
    logic            we0;
    logic [AW-1:0]   waddr0;
    logic [XLEN-1:0] wdata0;
    logic            we1;
    logic [AW-1:0]   waddr1;
    logic [XLEN-1:0] wdata1;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;

    modport master (
        input  init_busy, rs1_data, rs2_data, rs1_pend, rs2_pend,
        output rs1_addr, rs2_addr,
        output we0, waddr0, wdata0, we1, waddr1, wdata1,
        output issue_valid, issue_rd
    );

    modport slave (
        output init_busy, rs1_data, rs2_data, rs1_pend, rs2_pend,
        input  rs1_addr, rs2_addr,
        input  we0, waddr0, wdata0, we1, waddr1, wdata1,
        input  issue_valid, issue_rd
    );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with two read ports, two write-back ports and pending scoreboard
//
// Purpose: register file for the pipelined core. Reads are combinational, writes land on the
// rising edge, and a per-register pending bit lets the issue stage detect RAW hazards.
// After reset an internal sweep zeroes the array; register 0 always reads zero, never pending.
// Ports:
//   clk    in  clock, all state updates on the rising edge
//   rst_n  in  asynchronous active-low reset
//   rf     slave modport of regfile_sb_if (reads, write-back, issue, init_busy)
// Parameters:
//   XLEN   register width
//   AW     address width, NREG = 2**AW registers
//   BYPASS 1: reads see same-cycle write data and pending clears; 0: registered state only

module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_sb_if.slave   rf
);

    localparam int NREG = 2 ** AW;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_pend;

    logic            w_busy;
    logic            w_sweep_last;
    logic            w_wr0;
    logic            w_wr1;
    logic            w_iss;

    logic [AW-1:0]   w_raddr [2];
    logic [XLEN-1:0] w_rdata [2];
    logic            w_rpend [2];

    // Qualified write/issue strobes: nothing reaches the array or the scoreboard
    // during the sweep, and register 0 is filtered here once for every consumer.
    assign w_wr0 = !w_busy && rf.we0 && (rf.waddr0 != '0);
    assign w_wr1 = !w_busy && rf.we1 && (rf.waddr1 != '0);
    assign w_iss = !w_busy && rf.issue_valid && (rf.issue_rd != '0);

    assign w_sweep_last = (r_cnt == AW'(NREG - 1));

    // ------------------------------------------------------------------
    // Init FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SWEEP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SWEEP: if (w_sweep_last) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_SWEEP;
        endcase
    end

    always_comb begin
        w_busy = (r_state == ST_SWEEP);
    end

    assign rf.init_busy = w_busy;

    // Sweep index; wraps back to 0 on the last edge, which keeps it clean for the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage array: not reset directly, the sweep clears it.
    // Port 1 is assigned last so it wins on an address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_cnt] <= '0;
        end else begin
            if (w_wr0) r_mem[rf.waddr0] <= rf.wdata0;
            if (w_wr1) r_mem[rf.waddr1] <= rf.wdata1;
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard. The set from a same-edge issue is applied after the
    // clears: the issue belongs to a newer instruction than the write-back.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else if (!w_busy) begin
            if (w_wr0) r_pend[rf.waddr0] <= 1'b0;
            if (w_wr1) r_pend[rf.waddr1] <= 1'b0;
            if (w_iss) r_pend[rf.issue_rd] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    assign w_raddr[0] = rf.rs1_addr;
    assign w_raddr[1] = rf.rs2_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = r_mem[w_raddr[p]];
            w_rpend[p] = r_pend[w_raddr[p]];
            if (BYPASS) begin
                // Port 1 checked last so it overrides port 0 on a collision.
                if (w_wr0 && (rf.waddr0 == w_raddr[p])) begin
                    w_rdata[p] = rf.wdata0;
                    w_rpend[p] = 1'b0;
                end
                if (w_wr1 && (rf.waddr1 == w_raddr[p])) begin
                    w_rdata[p] = rf.wdata1;
                    w_rpend[p] = 1'b0;
                end
            end
            // Array may hold X before the sweep reaches it, so force zero while busy.
            if (w_busy || (w_raddr[p] == '0)) begin
                w_rdata[p] = '0;
                w_rpend[p] = 1'b0;
            end
        end
    end

    assign rf.rs1_data = w_rdata[0];
    assign rf.rs2_data = w_rdata[1];
    assign rf.rs1_pend = w_rpend[0];
    assign rf.rs2_pend = w_rpend[1];

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard testbench for regfile_sb (bypass, no-bypass and narrow instances)

module tb_regfile_sb;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .AW(5)) if_a ();
    regfile_sb_if #(.XLEN(32), .AW(5)) if_b ();
    regfile_sb_if #(.XLEN(16), .AW(3)) if_c ();

    regfile_sb #(.XLEN(32), .AW(5), .BYPASS(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .rf(if_a.slave));
    regfile_sb #(.XLEN(32), .AW(5), .BYPASS(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .rf(if_b.slave));
    regfile_sb #(.XLEN(16), .AW(3), .BYPASS(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .rf(if_c.slave));

    assign if_b.rs1_addr    = if_a.rs1_addr;
    assign if_b.rs2_addr    = if_a.rs2_addr;
    assign if_b.we0         = if_a.we0;
    assign if_b.waddr0      = if_a.waddr0;
    assign if_b.wdata0      = if_a.wdata0;
    assign if_b.we1         = if_a.we1;
    assign if_b.waddr1      = if_a.waddr1;
    assign if_b.wdata1      = if_a.wdata1;
    assign if_b.issue_valid = if_a.issue_valid;
    assign if_b.issue_rd    = if_a.issue_rd;

    localparam int S_A_RS1D = 0;
    localparam int S_A_RS2D = 1;
    localparam int S_A_RS1P = 2;
    localparam int S_A_RS2P = 3;
    localparam int S_A_BUSY = 4;
    localparam int S_B_RS1D = 5;
    localparam int S_B_RS2D = 6;
    localparam int S_B_RS1P = 7;
    localparam int S_B_BUSY = 8;
    localparam int S_C_RS1D = 9;
    localparam int S_C_RS1P = 10;
    localparam int S_C_BUSY = 11;

    typedef struct {
        int          sel;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [63:0] actual(int sel);
        case (sel)
            S_A_RS1D: return 64'(if_a.rs1_data);
            S_A_RS2D: return 64'(if_a.rs2_data);
            S_A_RS1P: return 64'(if_a.rs1_pend);
            S_A_RS2P: return 64'(if_a.rs2_pend);
            S_A_BUSY: return 64'(if_a.init_busy);
            S_B_RS1D: return 64'(if_b.rs1_data);
            S_B_RS2D: return 64'(if_b.rs2_data);
            S_B_RS1P: return 64'(if_b.rs1_pend);
            S_B_BUSY: return 64'(if_b.init_busy);
            S_C_RS1D: return 64'(if_c.rs1_data);
            S_C_RS1P: return 64'(if_c.rs1_pend);
            S_C_BUSY: return 64'(if_c.init_busy);
            default:  return 64'hDEAD_0000_DEAD_0000;
        endcase
    endfunction

    always @(negedge clk) begin
        chk_t        c;
        logic [63:0] act;
        while (q.size() > 0) begin
            c   = q.pop_front();
            act = actual(c.sel);
            n_vec++;
            if (act !== c.exp) begin
                n_bad++;
                $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
            end
        end
    end

    task automatic chk(input int sel, input logic [63:0] v, input string nm);
        chk_t c;
        c.sel  = sel;
        c.exp  = v;
        c.name = nm;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1);
    end

    initial begin
        if_a.rs1_addr = '0; if_a.rs2_addr = '0;
        if_a.we0 = 1'b0; if_a.waddr0 = '0; if_a.wdata0 = '0;
        if_a.we1 = 1'b0; if_a.waddr1 = '0; if_a.wdata1 = '0;
        if_a.issue_valid = 1'b0; if_a.issue_rd = '0;
        if_c.rs1_addr = '0; if_c.rs2_addr = '0;
        if_c.we0 = 1'b0; if_c.waddr0 = '0; if_c.wdata0 = '0;
        if_c.we1 = 1'b0; if_c.waddr1 = '0; if_c.wdata1 = '0;
        if_c.issue_valid = 1'b0; if_c.issue_rd = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        if_a.we0 = 1'b1; if_a.waddr0 = 5'd9; if_a.wdata0 = 32'h1234;
        if_a.issue_valid = 1'b1; if_a.issue_rd = 5'd9;
        if_a.rs1_addr = 5'd9;
        chk(S_A_BUSY, 1, "reset_busy_a");
        chk(S_B_BUSY, 1, "reset_busy_b");
        chk(S_C_BUSY, 1, "reset_busy_c");
        chk(S_A_RS1D, 0, "sweep_rd_zero");
        chk(S_A_RS1P, 0, "sweep_pend_zero");
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e == 7)  chk(S_C_BUSY, 1, "c_busy_edge7");
            if (e == 8)  chk(S_C_BUSY, 0, "c_busy_edge8");
            if (e == 31) begin
                chk(S_A_BUSY, 1, "a_busy_edge31");
                chk(S_B_BUSY, 1, "b_busy_edge31");
            end
            if (e == 32) begin
                chk(S_A_BUSY, 0, "a_busy_edge32");
                chk(S_B_BUSY, 0, "b_busy_edge32");
            end
        end
        if_a.we0 = 1'b0;
        if_a.issue_valid = 1'b0;

        for (int i = 0; i < 32; i++) begin
            if_a.rs1_addr = 5'(i);
            if_a.rs2_addr = 5'(31 - i);
            chk(S_A_RS1D, 0, "clr_rs1_data");
            chk(S_A_RS2D, 0, "clr_rs2_data");
            chk(S_A_RS1P, 0, "clr_rs1_pend");
            chk(S_A_RS2P, 0, "clr_rs2_pend");
            chk(S_B_RS1D, 0, "clr_b_rs1_data");
            step();
        end

        if_a.we0 = 1'b1; if_a.waddr0 = 5'd5; if_a.wdata0 = 32'hDEADBEEF;
        if_a.rs1_addr = 5'd5;
        chk(S_A_RS1D, 64'hDEADBEEF, "byp_same_cycle");
        chk(S_A_RS1P, 0, "byp_same_pend");
        chk(S_B_RS1D, 0, "nobyp_same_cycle");
        step();
        if_a.we0 = 1'b0;
        chk(S_A_RS1D, 64'hDEADBEEF, "byp_after_edge");
        chk(S_B_RS1D, 64'hDEADBEEF, "nobyp_after_edge");
        step();

        if_a.we0 = 1'b1; if_a.waddr0 = 5'd7; if_a.wdata0 = 32'h11;
        if_a.we1 = 1'b1; if_a.waddr1 = 5'd7; if_a.wdata1 = 32'h22;
        if_a.rs1_addr = 5'd7;
        chk(S_A_RS1D, 64'h22, "collide_byp");
        chk(S_B_RS1D, 0, "collide_nobyp_old");
        step();
        if_a.we0 = 1'b0; if_a.we1 = 1'b0;
        chk(S_A_RS1D, 64'h22, "collide_a_mem");
        chk(S_B_RS1D, 64'h22, "collide_b_mem");
        step();

        if_a.we0 = 1'b1; if_a.waddr0 = 5'd0; if_a.wdata0 = 32'hFFFFFFFF;
        if_a.we1 = 1'b1; if_a.waddr1 = 5'd0; if_a.wdata1 = 32'hFFFFFFFF;
        if_a.rs2_addr = 5'd0;
        chk(S_A_RS2D, 0, "r0_write_same");
        chk(S_A_RS2P, 0, "r0_pend_same");
        step();
        if_a.we0 = 1'b0; if_a.we1 = 1'b0;
        chk(S_A_RS2D, 0, "r0_after_a");
        chk(S_B_RS2D, 0, "r0_after_b");
        step();

        if_a.issue_valid = 1'b1; if_a.issue_rd = 5'd3;
        if_a.rs1_addr = 5'd3; if_a.rs2_addr = 5'd3;
        chk(S_A_RS1P, 0, "issue_same_cycle_a");
        chk(S_B_RS1P, 0, "issue_same_cycle_b");
        step();
        if_a.issue_valid = 1'b0;
        chk(S_A_RS1P, 1, "issue_pend_a");
        chk(S_A_RS2P, 1, "issue_pend_a_rs2");
        chk(S_B_RS1P, 1, "issue_pend_b");
        step();
        chk(S_A_RS1P, 1, "issue_pend_hold");
        step();
        if_a.we1 = 1'b1; if_a.waddr1 = 5'd3; if_a.wdata1 = 32'h55;
        chk(S_A_RS1P, 0, "wb_clear_byp");
        chk(S_A_RS1D, 64'h55, "wb_data_byp");
        chk(S_B_RS1P, 1, "wb_clear_nobyp_old");
        chk(S_B_RS1D, 0, "wb_data_nobyp_old");
        step();
        if_a.we1 = 1'b0;
        chk(S_A_RS1P, 0, "wb_clear_a");
        chk(S_B_RS1P, 0, "wb_clear_b");
        chk(S_A_RS1D, 64'h55, "wb_data_a");
        chk(S_B_RS1D, 64'h55, "wb_data_b");
        step();
        if_a.issue_valid = 1'b1; if_a.issue_rd = 5'd3;
        if_a.we0 = 1'b1; if_a.waddr0 = 5'd3; if_a.wdata0 = 32'h66;
        chk(S_A_RS1D, 64'h66, "iss_wr_byp_data");
        chk(S_A_RS1P, 0, "iss_wr_byp_pend");
        step();
        if_a.issue_valid = 1'b0; if_a.we0 = 1'b0;
        chk(S_A_RS1P, 1, "iss_wins_a");
        chk(S_B_RS1P, 1, "iss_wins_b");
        chk(S_A_RS1D, 64'h66, "iss_wr_data_a");
        chk(S_B_RS1D, 64'h66, "iss_wr_data_b");
        step();

        if_c.we0 = 1'b1; if_c.waddr0 = 3'd7; if_c.wdata0 = 16'hBEEF;
        if_c.rs1_addr = 3'd7;
        chk(S_C_RS1D, 64'hBEEF, "c_byp_beef");
        step();
        if_c.we0 = 1'b0;
        chk(S_C_RS1D, 64'hBEEF, "c_mem_beef");
        step();
        if_c.issue_valid = 1'b1; if_c.issue_rd = 3'd0; if_c.rs1_addr = 3'd0;
        step();
        if_c.issue_valid = 1'b0;
        chk(S_C_RS1P, 0, "c_r0_never_pend");
        chk(S_C_RS1D, 0, "c_r0_data");
        step();
        if_c.issue_valid = 1'b1; if_c.issue_rd = 3'd7; if_c.rs1_addr = 3'd7;
        step();
        if_c.issue_valid = 1'b0;
        chk(S_C_RS1P, 1, "c_r7_pend");
        step();

        if_a.we0 = 1'b1; if_a.waddr0 = 5'd4; if_a.wdata0 = 32'hAA;
        if_a.rs1_addr = 5'd4;
        step();
        if_a.we0 = 1'b0;
        chk(S_A_RS1D, 64'hAA, "r4_written");
        step();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        chk(S_A_BUSY, 1, "rst1_busy");
        chk(S_A_RS1D, 0, "rst1_rd_zero");
        for (int e = 1; e <= 10; e++) step();
        chk(S_A_BUSY, 1, "busy_at_cnt10");
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        chk(S_A_BUSY, 1, "rst2_busy");
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e == 31) chk(S_A_BUSY, 1, "restart_busy_edge31");
            if (e == 32) chk(S_A_BUSY, 0, "restart_busy_edge32");
        end
        if_a.rs1_addr = 5'd4;
        if_a.rs2_addr = 5'd3;
        chk(S_A_RS1D, 0, "r4_cleared");
        chk(S_A_RS2P, 0, "r3_pend_cleared");
        chk(S_C_RS1P, 0, "c_pend_cleared");
        step();

        step();
        step();
        if (if_a.init_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL final_busy_a: got %0b expected 0", if_a.init_busy);
        end
        if (if_c.init_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL final_busy_c: got %0b expected 0", if_c.init_busy);
        end
        if (n_vec == 0) begin
            n_bad++;
            $display("FAIL vec_count: got 0 expected nonzero");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad != 0) $display("FAIL: %0d miscompares", n_bad);
        else            $display("PASS");
        $finish;
    end

endmodule
